lfsr_stream_cipher: RTL and testbench

//  Hardware LFSR stream-cipher engine: walks a byte block in data memory, encrypts or

---
 rtl/lfsr_crypt_pkg.sv | 34 +++
 rtl/lfsr_gen.sv | 29 ++
 rtl/lfsr_stream_cipher.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_lfsr_stream_cipher.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_crypt_pkg.sv
// Shared definitions for the LFSR stream-cipher engine: FSM state codes,
// the tap-pattern table searched during key recovery (LW = 7), and the
// width-generic Fibonacci LFSR step function.
package lfsr_crypt_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_SCAN = 3'd2;
    localparam state_t ST_RD   = 3'd3;
    localparam state_t ST_WR   = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    // Widest LFSR the step function supports; narrower registers are zero-extended.
    localparam int LFSR_MAXW = 16;

    localparam int PTRN_TABLE_LEN = 9;
    localparam logic [6:0] LFSR_PTRN_TABLE [0:PTRN_TABLE_LEN-1] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    // One Fibonacci step on the low w bits: shift left, feedback = parity of tapped bits.
    function automatic logic [LFSR_MAXW-1:0] lfsr_next(
        input logic [LFSR_MAXW-1:0] s,
        input logic [LFSR_MAXW-1:0] p,
        input int                   w
    );
        logic [LFSR_MAXW-1:0] mask;
        mask = {LFSR_MAXW{1'b1}} >> (LFSR_MAXW - w);
        return ((s << 1) | LFSR_MAXW'(^(s & p & mask))) & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// LW-bit Fibonacci LFSR register. Load has priority over step; the tap
// pattern is an input so the same register serves both the cipher run and
// the candidate search during key recovery.
module lfsr_gen
    import lfsr_crypt_pkg::*;
#(
    parameter int LW = 7
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          load,
    input  logic          step,
    input  logic [LW-1:0] load_val,
    input  logic [LW-1:0] ptrn,
    output logic [LW-1:0] state
);

    // Keystream register: resets to 1 so it can never sit in the all-zero lock-up state.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= LW'(1);
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= LW'(lfsr_next(LFSR_MAXW'(state), LFSR_MAXW'(ptrn), LW));
        end
    end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream-cipher engine. Walks msg_len bytes from src_base, XORs each with
// the keystream (encrypt also removes the ASCII bias first) and writes the
// result to dst_base. A run is launched by req falling and ends in DONE with
// ack held until req rises again. Raising req mid-run aborts to IDLE.
// Optional feature macro: LFSR_KEY_RECOVER_EN -- decrypt recovers tap pattern
// and seed from a known run of leading space bytes (adds PRE_MIN / NUM_PTRN).
module lfsr_stream_cipher
    import lfsr_crypt_pkg::*;
#(
    parameter int             LW      = 7,
    parameter int             DW      = 8,
    parameter int             AW      = 8,
    parameter int             MSG_LEN = 64,
    parameter logic [DW-1:0]  BIAS    = 8'h20
`ifdef LFSR_KEY_RECOVER_EN
    ,
    parameter int             PRE_MIN  = 10,
    parameter int             NUM_PTRN = 9
`endif
) (
    input  logic                         clk,
    input  logic                         init_n,
    input  logic                         req,
    input  logic                         mode,
    input  logic [AW-1:0]                src_base,
    input  logic [AW-1:0]                dst_base,
    input  logic [$clog2(MSG_LEN+1)-1:0] msg_len,
    input  logic [LW-1:0]                ptrn_in,
    input  logic [LW-1:0]                seed_in,
    output logic [AW-1:0]                mem_addr,
    output logic                         mem_rd_en,
    input  logic [DW-1:0]                mem_rdata,
    output logic                         mem_wr_en,
    output logic [DW-1:0]                mem_wdata,
    output logic                         busy,
    output logic                         ack,
    output logic                         key_err,
    output logic [3:0]                   key_idx
);

    localparam int CW = $clog2(MSG_LEN+1);

    state_t        state;
    logic          req_q;
    logic          launch_q;
    logic          mode_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] idx;
    logic [LW-1:0] ptrn_q;

    logic          launch;
    logic [CW-1:0] len_clip;
    logic [LW-1:0] seed_fix;
    logic [DW-1:0] src_byte;
    logic [DW-1:0] crypt_byte;

    logic          gen_load;
    logic          gen_step;
    logic [LW-1:0] gen_load_val;
    logic [LW-1:0] gen_ptrn;
    logic [LW-1:0] lfsr_state;

`ifdef LFSR_KEY_RECOVER_EN
    localparam int KW = $clog2(PRE_MIN);

    logic [LW-1:0] kb [0:PRE_MIN-1];
    logic          ph;
    logic [KW-1:0] kw;
    logic [KW-1:0] kj;
    logic [3:0]    k_q;
    logic [LW-1:0] scan_ptrn;
    logic [LW-1:0] scan_cand;
    logic [LW-1:0] kb_seed;
    logic          scan_match;
    logic          scan_last;
`endif

    // Launch is req seen high on the previous edge and low on this one, while idle.
    assign launch   = (state == ST_IDLE) && req_q && !req;
    assign len_clip = (msg_len > CW'(MSG_LEN)) ? CW'(MSG_LEN) : msg_len;
    assign seed_fix = (seed_in == '0) ? LW'(1) : seed_in;

    // Bits above LW pass through; subtraction wraps modulo 2**DW.
    assign src_byte   = mode_q ? mem_rdata : (mem_rdata - BIAS);
    assign crypt_byte = src_byte ^ DW'(lfsr_state);

`ifdef LFSR_KEY_RECOVER_EN
    // Candidate check: the pad bytes encrypt to the bare keystream, so each
    // buffered byte must equal the next LFSR state under the trial pattern.
    assign scan_ptrn  = LW'(LFSR_PTRN_TABLE[k_q]);
    assign scan_cand  = LW'(lfsr_next(LFSR_MAXW'(lfsr_state), LFSR_MAXW'(scan_ptrn), LW));
    assign scan_match = (scan_cand == kb[kj]);
    assign scan_last  = (kj == KW'(PRE_MIN-1));
    assign kb_seed    = (kb[0] == '0) ? LW'(1) : kb[0];
`endif

    // Keystream register control: seed at launch, step after each write, search during SCAN.
    always_comb begin
        gen_load     = 1'b0;
        gen_step     = 1'b0;
        gen_load_val = seed_fix;
        gen_ptrn     = ptrn_q;
        if (launch) begin
            gen_load = 1'b1;
        end
        if (state == ST_WR && !req) begin
            gen_step = 1'b1;
        end
`ifdef LFSR_KEY_RECOVER_EN
        if (state == ST_SCAN) begin
            gen_ptrn     = scan_ptrn;
            gen_load_val = kb_seed;
            if (!scan_match || scan_last) begin
                gen_load = 1'b1;
            end else begin
                gen_step = 1'b1;
            end
        end
`endif
    end

    lfsr_gen #(
        .LW       (LW)
    ) u_lfsr_gen (
        .clk      (clk),
        .init_n   (init_n),
        .load     (gen_load),
        .step     (gen_step),
        .load_val (gen_load_val),
        .ptrn     (gen_ptrn),
        .state    (lfsr_state)
    );

    // Run control FSM and launch-time capture of the job parameters.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state    <= ST_IDLE;
            req_q    <= 1'b0;
            launch_q <= 1'b0;
            mode_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            ptrn_q   <= '0;
`ifdef LFSR_KEY_RECOVER_EN
            key_err  <= 1'b0;
            key_idx  <= '0;
            ph       <= 1'b0;
            kw       <= '0;
            kj       <= '0;
            k_q      <= '0;
`endif
        end else begin
            req_q    <= req;
            launch_q <= launch;
            if (launch) begin
                mode_q  <= mode;
                src_q   <= src_base;
                dst_q   <= dst_base;
                len_q   <= len_clip;
                ptrn_q  <= ptrn_in;
`ifdef LFSR_KEY_RECOVER_EN
                key_err <= 1'b0;
                key_idx <= '0;
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (launch_q && !req) begin
                        idx <= '0;
                        if (len_q == '0) begin
                            state <= ST_DONE;
`ifdef LFSR_KEY_RECOVER_EN
                        end else if (mode_q) begin
                            if (len_q < CW'(PRE_MIN)) begin
                                key_err <= 1'b1;
                                state   <= ST_DONE;
                            end else begin
                                ph    <= 1'b0;
                                kw    <= '0;
                                state <= ST_LOAD;
                            end
`endif
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= req ? ST_IDLE : ST_WR;
                end
                ST_WR: begin
                    if (req) begin
                        state <= ST_IDLE;
                    end else begin
                        idx   <= idx + CW'(1);
                        state <= ((idx + CW'(1)) == len_q) ? ST_DONE : ST_RD;
                    end
                end
                ST_DONE: begin
                    if (req) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef LFSR_KEY_RECOVER_EN
                ST_LOAD: begin
                    if (req) begin
                        state <= ST_IDLE;
                    end else if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        ph <= 1'b0;
                        if (kw == KW'(PRE_MIN-1)) begin
                            k_q   <= '0;
                            kj    <= KW'(1);
                            state <= ST_SCAN;
                        end else begin
                            kw <= kw + KW'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (req) begin
                        state <= ST_IDLE;
                    end else if (scan_match) begin
                        if (scan_last) begin
                            key_idx <= k_q;
                            ptrn_q  <= scan_ptrn;
                            idx     <= '0;
                            state   <= ST_RD;
                        end else begin
                            kj <= kj + KW'(1);
                        end
                    end else if (k_q == 4'(NUM_PTRN-1)) begin
                        key_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        k_q <= k_q + 4'd1;
                        kj  <= KW'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_KEY_RECOVER_EN
    // Pad-byte buffer filled on the data-return half of each LOAD byte.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && ph) begin
            kb[kw] <= mem_rdata[LW-1:0];
        end
    end
`else
    assign key_err = 1'b0;
    assign key_idx = 4'd0;
`endif

    // Memory port and status decode; everything is zero outside an active phase.
    always_comb begin
        busy      = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_RD: begin
                busy      = 1'b1;
                mem_addr  = src_q + AW'(idx);
                mem_rd_en = 1'b1;
            end
            ST_WR: begin
                busy      = 1'b1;
                mem_addr  = dst_q + AW'(idx);
                mem_wr_en = 1'b1;
                mem_wdata = crypt_byte;
            end
`ifdef LFSR_KEY_RECOVER_EN
            ST_LOAD: begin
                busy      = 1'b1;
                mem_addr  = src_q + AW'(kw);
                mem_rd_en = !ph;
            end
            ST_SCAN: begin
                busy = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign ack = (state == ST_DONE);

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Bench for lfsr_stream_cipher: byte memory model, write scoreboard fed by a
// reference keystream model, latency and control checks. Key-recovery cases
// are compiled in with LFSR_KEY_RECOVER_EN.
module tb_lfsr_stream_cipher;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       init_n;
    logic       req;
    logic       mode;
    logic [7:0] src_base;
    logic [7:0] dst_base;
    logic [6:0] msg_len;
    logic [6:0] ptrn_in;
    logic [6:0] seed_in;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       ack;
    logic       key_err;
    logic [3:0] key_idx;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] orig    [0:63];
    wr_t        exp_q   [$];

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int overlap  = 0;

    lfsr_stream_cipher dut (
        .clk       (clk),
        .init_n    (init_n),
        .req       (req),
        .mode      (mode),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .msg_len   (msg_len),
        .ptrn_in   (ptrn_in),
        .seed_in   (seed_in),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .ack       (ack),
        .key_err   (key_err),
        .key_idx   (key_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory: one-cycle read latency, write on the strobe edge.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
    end

    // Write monitor: every DUT write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (init_n) begin
            if (mem_rd_en && mem_wr_en) overlap++;
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) begin
                wr_t e;
                wr_cnt++;
                check_eq("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", mem_addr, e.addr);
                    check_eq("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    // Reference model of a run over ref_mem; optionally queues expected writes.
    task automatic push_run(input bit md, input logic [7:0] s, input logic [7:0] d, input int n,
                            input logic [6:0] p, input logic [6:0] sd, input bit do_push);
        logic [6:0] st;
        logic [7:0] b;
        wr_t        e;
        st = (sd == 7'd0) ? 7'd1 : sd;
        for (int i = 0; i < n; i++) begin
            b = ref_mem[8'(s + i)];
            if (!md) b = b - 8'h20;
            b = b ^ {1'b0, st};
            ref_mem[8'(d + i)] = b;
            if (do_push) begin
                e.addr = 8'(d + i);
                e.data = b;
                exp_q.push_back(e);
            end
            st = {st[5:0], ^(st & p)};
        end
    endtask

    task automatic launch(input bit md, input logic [7:0] s, input logic [7:0] d,
                          input logic [6:0] n, input logic [6:0] p, input logic [6:0] sd);
        @(negedge clk);
        mode = md; src_base = s; dst_base = d; msg_len = n; ptrn_in = p; seed_in = sd;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
    endtask

    // Counts edges after the launch edge until ack is seen; bounded.
    task automatic wait_ack(input int budget, output int cyc, output logic busy1);
        logic got;
        cyc = 0; got = 1'b0; busy1 = 1'b0;
        while (cyc < budget && !got) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) busy1 = busy;
            got = ack;
        end
        check_eq("ack_seen", ack, 1);
    endtask

    task automatic end_run(input string tag);
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, ack, 0);
    endtask

    initial begin
        int   cyc;
        logic b1;
        int   rd0, wr0, mism;
        logic found;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'hEE;
            ref_mem[i] = 8'hEE;
        end
        init_n = 1'b0; req = 1'b1; mode = 1'b0; src_base = '0; dst_base = '0;
        msg_len = '0; ptrn_in = '0; seed_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_rd_en", mem_rd_en, 0);
        check_eq("rst_wr_en", mem_wr_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_key", {key_err, key_idx}, 0);
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: two-byte encrypt, known answer and latency 2N+1
        mem[8'h10] = 8'h20; mem[8'h11] = 8'h20;
        exp_q.push_back('{addr: 8'h40, data: 8'h35});
        exp_q.push_back('{addr: 8'h41, data: 8'h6A});
        launch(1'b0, 8'h10, 8'h40, 7'd2, 7'h5C, 7'h35);
        wait_ack(50, cyc, b1);
        check_eq("t1_busy_first", b1, 1);
        check_eq("t1_latency", cyc, 5);
        check_eq("t1_busy_done", busy, 0);
        end_run("t1_ack_drop");

        // 2: zero length finishes next cycle without touching memory
        rd0 = rd_cnt; wr0 = wr_cnt;
        launch(1'b0, 8'h10, 8'h40, 7'd0, 7'h5C, 7'h35);
        wait_ack(20, cyc, b1);
        check_eq("t2_latency", cyc, 1);
        check_eq("t2_no_access", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        end_run("t2_ack_drop");

        // 3: 64-byte encrypt with wrapping source and clipped length, then decrypt back
        for (int i = 0; i < 64; i++) begin
            orig[i] = (i < 10) ? 8'h20 : 8'($urandom_range(32, 126));
            mem[8'(8'hF0 + i)] = orig[i];
            ref_mem[8'(8'hF0 + i)] = orig[i];
        end
        push_run(1'b0, 8'hF0, 8'h80, 64, 7'h5C, 7'h35, 1'b1);
        launch(1'b0, 8'hF0, 8'h80, 7'd100, 7'h5C, 7'h35);
        wait_ack(400, cyc, b1);
        check_eq("t3_enc_latency", cyc, 129);
        end_run("t3_enc_ack_drop");
        push_run(1'b1, 8'h80, 8'h30, 64, 7'h5C, 7'h35, 1'b1);
        launch(1'b1, 8'h80, 8'h30, 7'd64, 7'h5C, 7'h35);
        wait_ack(400, cyc, b1);
`ifdef LFSR_KEY_RECOVER_EN
        check_eq("t3_key_idx", key_idx, 6);
        check_eq("t3_key_err", key_err, 0);
`else
        check_eq("t3_dec_latency", cyc, 129);
        check_eq("t3_key_outputs", {key_err, key_idx}, 0);
`endif
        mism = 0;
        for (int i = 0; i < 64; i++) begin
            if (8'(mem[8'(8'h30 + i)] + 8'h20) !== orig[i]) mism++;
        end
        check_eq("t3_roundtrip", mism, 0);
        end_run("t3_dec_ack_drop");

        // 4: abort after byte 3 is written
        push_run(1'b0, 8'h50, 8'hC0, 4, 7'h48, 7'h11, 1'b1);
        launch(1'b0, 8'h50, 8'hC0, 7'd8, 7'h48, 7'h11);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (mem_wr_en && mem_addr == 8'hC3) found = 1'b1;
        end
        check_eq("t4_byte3_written", found, 1);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t4_busy_after_abort", busy, 0);
        wr0 = wr_cnt;
        repeat (6) @(negedge clk);
        check_eq("t4_ack_stays_low", ack, 0);
        check_eq("t4_no_more_writes", wr_cnt - wr0, 0);
        check_eq("t4_byte4_untouched", mem[8'hC4], 8'hEE);

        // 5: asynchronous reset during a write, then a clean relaunch (seed 0 -> 1)
        for (int i = 0; i < 4; i++) begin
            mem[8'h60 + i] = 8'($urandom_range(32, 126));
            ref_mem[8'h60 + i] = mem[8'h60 + i];
        end
        push_run(1'b0, 8'h60, 8'hD0, 1, 7'h7E, 7'h00, 1'b1);
        launch(1'b0, 8'h60, 8'hD0, 7'd4, 7'h7E, 7'h00);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (mem_wr_en) found = 1'b1;
        end
        check_eq("t5_in_write", found, 1);
        #2 init_n = 1'b0;
        #1;
        check_eq("t5_rst_outputs", {busy, ack, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        init_n = 1'b1;
        push_run(1'b0, 8'h60, 8'hD0, 3, 7'h7E, 7'h00, 1'b1);
        launch(1'b0, 8'h60, 8'hD0, 7'd3, 7'h7E, 7'h00);
        wait_ack(50, cyc, b1);
        check_eq("t5_relaunch_latency", cyc, 7);
        end_run("t5_ack_drop");

`ifdef LFSR_KEY_RECOVER_EN
        // 6: key recovery from a padded ciphertext, then failing cases
        for (int i = 0; i < 16; i++) begin
            ref_mem[8'h00 + i] = (i < 10) ? 8'h20 : 8'($urandom_range(65, 90));
        end
        push_run(1'b0, 8'h00, 8'hA0, 16, 7'h5C, 7'h35, 1'b0);
        for (int i = 0; i < 16; i++) mem[8'hA0 + i] = ref_mem[8'hA0 + i];
        push_run(1'b1, 8'hA0, 8'hB0, 16, 7'h5C, 7'h35, 1'b1);
        launch(1'b1, 8'hA0, 8'hB0, 7'd16, 7'h01, 7'h02);
        wait_ack(400, cyc, b1);
        check_eq("t6_key_idx", key_idx, 6);
        check_eq("t6_key_err", key_err, 0);
        end_run("t6_ack_drop");

        for (int i = 0; i < 12; i++) mem[8'h70 + i] = 8'h7F;
        wr0 = wr_cnt;
        launch(1'b1, 8'h70, 8'hB0, 7'd12, 7'h01, 7'h02);
        wait_ack(400, cyc, b1);
        check_eq("t6_7f_key_err", key_err, 1);
        check_eq("t6_7f_no_writes", wr_cnt - wr0, 0);
        end_run("t6_7f_ack_drop");

        wr0 = wr_cnt;
        launch(1'b1, 8'hA0, 8'hB0, 7'd5, 7'h01, 7'h02);
        wait_ack(50, cyc, b1);
        check_eq("t6_short_key_err", key_err, 1);
        check_eq("t6_short_no_writes", wr_cnt - wr0, 0);
        end_run("t6_short_ack_drop");
`endif

        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("rd_wr_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
